// File: rtl/uart_pkg.sv
// Definitions shared by the UART receiver and transmitter: state encoding,
// default frame geometry and the parity helper.
package uart_pkg;

  localparam int UART_OVS       = 16;
  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Zero-extension of narrower data leaves the XOR reduction unchanged.
  function automatic logic par(input logic [31:0] data, input logic mode);
    return mode ? ^data : ~^data;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; reset value is
// chosen per use so an idle-high line does not look like activity.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/receiver.sv
// UART receiver: oversampled start detection, LSB-first data, optional
// parity, mid-stop-bit delivery with parity/framing status.
module receiver
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS,
  parameter int OVS       = UART_OVS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_Clock,
  input  logic                 rx,
  input  logic                 parity_en,
  input  logic                 parity_mode,
  output logic [DATA_BITS-1:0] data_rx,
  output logic                 rx_done_tick,
  output logic                 parity_error,
  output logic                 framing_error
);

  localparam int SW = $clog2(OVS);
  localparam int NW = $clog2(DATA_BITS);
  localparam logic [SW-1:0] S_HALF = SW'(OVS/2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVS - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);

  logic rx_s;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  uart_state_e          state_q, state_d;
  logic [SW-1:0]        s_q, s_d;
  logic [NW-1:0]        n_q, n_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 armed_q, armed_d;
  logic                 pen_q, pen_d;
  logic                 pmode_q, pmode_d;
  logic                 prx_q, prx_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      sh_q    <= '0;
      armed_q <= 1'b0;
      pen_q   <= 1'b0;
      pmode_q <= 1'b0;
      prx_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      sh_q    <= sh_d;
      armed_q <= armed_d;
      pen_q   <= pen_d;
      pmode_q <= pmode_d;
      prx_q   <= prx_d;
      data_q  <= data_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    sh_d    = sh_q;
    armed_d = armed_q;
    pen_d   = pen_q;
    pmode_d = pmode_q;
    prx_d   = prx_q;
    data_d  = data_q;
    done_d  = 1'b0;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    case (state_q)
      IDLE: begin
        // A start is accepted only after the line has been seen high, so a
        // held-low break yields a single frame rather than a stream of them.
        if (!rx_s && armed_q) begin
          state_d = START;
          s_d     = '0;
          armed_d = 1'b0;
          pen_d   = parity_en;
          pmode_d = parity_mode;
        end else if (rx_s) begin
          armed_d = 1'b1;
        end
      end
      START: if (i_Clock) begin
        if (s_q == S_HALF) begin
          if (!rx_s) begin
            state_d = DATA;
            s_d     = '0;
            n_d     = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          s_d = s_q + SW'(1);
        end
      end
      DATA: if (i_Clock) begin
        if (s_q == S_LAST) begin
          sh_d = {rx_s, sh_q[DATA_BITS-1:1]};
          s_d  = '0;
          if (n_q == N_LAST) state_d = pen_q ? PARITY : STOP;
          else               n_d     = n_q + NW'(1);
        end else begin
          s_d = s_q + SW'(1);
        end
      end
      PARITY: if (i_Clock) begin
        if (s_q == S_LAST) begin
          prx_d   = rx_s;
          state_d = STOP;
          s_d     = '0;
        end else begin
          s_d = s_q + SW'(1);
        end
      end
      STOP: if (i_Clock) begin
        // Leaving at mid stop bit leaves half a bit of slack for the next start.
        if (s_q == S_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
          data_d  = sh_q;
          ferr_d  = ~rx_s;
          perr_d  = pen_q & (prx_q != par(32'(sh_q), pmode_q));
        end else begin
          s_d = s_q + SW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_rx       = data_q;
  assign rx_done_tick  = done_q;
  assign parity_error  = perr_q;
  assign framing_error = ferr_q;

endmodule

// File: tb/tb_receiver.sv
// Bench for the UART receiver: directed frame table, hand-written break,
// glitch and reset sequences, then randomized frames against a frame model.
module tb_receiver;

  localparam int OVS  = 16;
  localparam int TDIV = 4;

  logic       clk = 1'b0, rst_n = 1'b0, i_Clock = 1'b0, rx = 1'b1;
  logic       parity_en = 1'b0, parity_mode = 1'b0;
  logic [7:0] data_rx;
  logic       rx_done_tick, parity_error, framing_error;

  int n_cmp = 0, n_bad = 0, n_strobe = 0, exp_strobe = 0, tcnt = 0;

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       f;
  } rec_t;
  rec_t got_q[$];

  typedef struct {
    logic [7:0] d;
    logic       pen, pmode, pflip, stopv;
    logic [7:0] ed;
    logic       ep, ef;
  } vec_t;
  vec_t tbl[5];

  receiver dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_Clock       (i_Clock),
    .rx            (rx),
    .parity_en     (parity_en),
    .parity_mode   (parity_mode),
    .data_rx       (data_rx),
    .rx_done_tick  (rx_done_tick),
    .parity_error  (parity_error),
    .framing_error (framing_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    tcnt    = (tcnt + 1) % TDIV;
    i_Clock = (tcnt == 0);
  end

  always @(negedge clk) begin
    if (rx_done_tick) begin
      got_q.push_back('{data_rx, parity_error, framing_error});
      n_strobe++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      do @(posedge clk); while (i_Clock !== 1'b1);
    end
    @(negedge clk);
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    wait_ticks(OVS);
  endtask

  task automatic idle_bits(input int b);
    rx = 1'b1;
    if (b > 0) wait_ticks(b * OVS);
  endtask

  // Transmitter model: start, LSB-first data, optional parity, stop.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pmode,
                            input logic pflip, input logic stopv, input logic scramble);
    logic pbit;
    parity_en   = pen;
    parity_mode = pmode;
    drive_bit(1'b0);
    if (scramble) begin
      parity_en   = 1'($urandom);
      parity_mode = 1'($urandom);
    end
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    pbit = 1'b0;
    for (int i = 0; i < 8; i++) pbit = pbit ^ d[i];
    if (!pmode) pbit = ~pbit;
    if (pen) drive_bit(pbit ^ pflip);
    drive_bit(stopv);
    exp_strobe++;
  endtask

  task automatic check_next(input string tag, input logic [7:0] ed, input logic ep, input logic ef);
    rec_t r;
    for (int k = 0; k < 200 && got_q.size() == 0; k++) @(posedge clk);
    if (got_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no rx_done_tick seen, expected data %0h", tag, ed);
    end else begin
      r = got_q.pop_front();
      chk({tag, ".data"}, 32'(r.d), 32'(ed));
      chk({tag, ".perr"}, 32'(r.p), 32'(ep));
      chk({tag, ".ferr"}, 32'(r.f), 32'(ef));
    end
    @(negedge clk);
  endtask

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    logic [7:0] rd;
    logic rpen, rpmode, rflip, rstop;
    int rgap;

    tbl[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{8'h81, 1'b1, 1'b0, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0};
    tbl[2] = '{8'h6E, 1'b1, 1'b0, 1'b1, 1'b1, 8'h6E, 1'b1, 1'b0};
    tbl[3] = '{8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
    tbl[4] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};

    repeat (5) @(negedge clk);
    chk("reset.data", 32'(data_rx), 32'h0);
    chk("reset.done", 32'(rx_done_tick), 32'h0);
    chk("reset.perr", 32'(parity_error), 32'h0);
    chk("reset.ferr", 32'(framing_error), 32'h0);
    rst_n = 1'b1;
    idle_bits(2);

    for (int i = 0; i < 5; i++) begin
      send_frame(tbl[i].d, tbl[i].pen, tbl[i].pmode, tbl[i].pflip, tbl[i].stopv, 1'b0);
      check_next($sformatf("tbl%0d", i), tbl[i].ed, tbl[i].ep, tbl[i].ef);
      idle_bits(1);
    end

    // Reset during data bit 4 of 0xF0; prior status is 0x3C with parity error.
    base = n_strobe;
    parity_en = 1'b0;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    rx = 1'b1;
    wait_ticks(OVS / 2);
    rst_n = 1'b0;
    #1;
    chk("midrst.data", 32'(data_rx), 32'h0);
    chk("midrst.done", 32'(rx_done_tick), 32'h0);
    chk("midrst.perr", 32'(parity_error), 32'h0);
    chk("midrst.ferr", 32'(framing_error), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle_bits(8);
    chk("midrst.nostrobe", 32'(n_strobe - base), 32'd0);
    send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_next("after_rst", 8'h0F, 1'b0, 1'b0);
    idle_bits(1);

    // Framing error followed by a held-low line.
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_next("frame_err", 8'h55, 1'b0, 1'b1);
    base = n_strobe;
    rx = 1'b0;
    wait_ticks(3 * 10 * OVS);
    chk("held_low.nostrobe", 32'(n_strobe - base), 32'd0);
    idle_bits(2);

    // Break from idle: exactly one 0x00 frame with framing error.
    base = n_strobe;
    rx = 1'b0;
    wait_ticks(30 * OVS);
    chk("break.count", 32'(n_strobe - base), 32'd1);
    exp_strobe++;
    check_next("break", 8'h00, 1'b0, 1'b1);
    idle_bits(2);

    // Five-tick glitch must not start a frame.
    base = n_strobe;
    rx = 1'b0;
    wait_ticks(5);
    idle_bits(2);
    chk("glitch.nostrobe", 32'(n_strobe - base), 32'd0);
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_next("post_glitch", 8'h81, 1'b0, 1'b0);
    idle_bits(1);

    // Back-to-back frames, no idle gap.
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle_bits(1);
    check_next("b2b0", 8'h00, 1'b0, 1'b0);
    check_next("b2b1", 8'hFF, 1'b0, 1'b0);
    check_next("b2b2", 8'h12, 1'b0, 1'b0);

    // Randomized frames; control inputs scrambled mid-frame.
    for (int i = 0; i < 24; i++) begin
      rd     = 8'($urandom);
      rpen   = 1'($urandom);
      rpmode = 1'($urandom);
      rflip  = rpen && ($urandom_range(0, 3) == 0);
      rstop  = ($urandom_range(0, 4) != 0);
      rgap   = rstop ? $urandom_range(0, 2) : 1 + $urandom_range(0, 1);
      send_frame(rd, rpen, rpmode, rflip, rstop, 1'b1);
      check_next($sformatf("rnd%0d", i), rd, rflip, ~rstop);
      idle_bits(rgap);
    end

    idle_bits(2);
    chk("strobe_total", 32'(n_strobe), 32'(exp_strobe));
    chk("queue_empty", 32'(got_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
